bus_mux_arb: RTL and testbench

//  Parametrised, registered source-select mux for the processor datapath bus.

---
 rtl/bus_mux_arb.sv | 173 +++++++++++++++++
 tb/tb_bus_mux_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_arb.sv
// -----------------------------------------------------------------------------
// bus_mux_arb
//
// Registered source-select mux for the processor datapath bus. The control FSM
// picks one source with a one-hot select: a general register, DIN, G, the
// constant 0 or the constant 1. The chosen value appears on BusWires one edge
// after the select is sampled.
//
// If more than one select bit is set on an edge, that edge is a conflict. A
// conflict pulses Conflict, sets ConflictSticky, bumps a saturating counter,
// captures the offending select vector and moves the FSM to FAULT. With
// LOCK_ON_FAULT=1 the bus stays frozen in FAULT until ClearErr arrives on an
// edge that has no conflict.
//
// Ports
//   Clock          in   1            rising-edge clock
//   Resetn         in   1            asynchronous active-low reset
//   Rout           in   N_REGS       one-hot register select (bit k -> Rk)
//   DINout         in   1            select DIN
//   Gout           in   1            select G
//   ZeroOut        in   1            select constant 0
//   OneOut         in   1            select constant 1 (zero-extended)
//   R_flat         in   N_REGS*W     register data, Rk = R_flat[k*W +: W]
//   DIN            in   W            external data input
//   G              in   W            ALU result register
//   ClearErr       in   1            clear sticky error / leave FAULT
//   BusWires       out  W            registered bus value
//   BusValid       out  1            last edge loaded a legal single select
//   Conflict       out  1            last edge saw more than one select bit
//   ConflictSticky out  1            any conflict since the last ClearErr
//   ConflictCount  out  CNT_W        saturating count of conflict edges
//   LastConflSel   out  N_REGS+4     select vector at the most recent conflict
// -----------------------------------------------------------------------------
module bus_mux_arb #(
    parameter int W             = 16,
    parameter int N_REGS        = 8,
    parameter bit HOLD_LAST     = 1'b1,
    parameter bit LOCK_ON_FAULT = 1'b0,
    parameter int CNT_W         = 8
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [N_REGS-1:0]     Rout,
    input  logic                  DINout,
    input  logic                  Gout,
    input  logic                  ZeroOut,
    input  logic                  OneOut,
    input  logic [N_REGS*W-1:0]   R_flat,
    input  logic [W-1:0]          DIN,
    input  logic [W-1:0]          G,
    input  logic                  ClearErr,
    output logic [W-1:0]          BusWires,
    output logic                  BusValid,
    output logic                  Conflict,
    output logic                  ConflictSticky,
    output logic [CNT_W-1:0]      ConflictCount,
    output logic [N_REGS+3:0]     LastConflSel
);

    localparam int SEL_W = N_REGS + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [SEL_W-1:0]   sel;
    logic               sel_none;
    logic               sel_multi;
    logic               sel_single;
    logic               locked;
    logic [W-1:0]       mux_val;

    logic [W-1:0]       bus_next;
    logic               valid_next;
    logic               confl_next;
    logic               sticky_next;
    logic [CNT_W-1:0]   count_next;
    logic [SEL_W-1:0]   last_next;

    assign sel = {OneOut, ZeroOut, Gout, DINout, Rout};

    // Clearing the lowest set bit leaves something only if two or more bits
    // were set, so the population count never has to be computed.
    assign sel_none   = ~|sel;
    assign sel_multi  = |(sel & (sel - SEL_W'(1)));
    assign sel_single = ~sel_none & ~sel_multi;

    assign locked = LOCK_ON_FAULT && (state == FAULT);

    // AND-OR mux. The result is only used when exactly one select bit is set,
    // so OR-ing the masked sources gives the selected one without priority.
    always_comb begin
        mux_val = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (Rout[k]) begin
                mux_val = mux_val | R_flat[k*W +: W];
            end
        end
        if (DINout) mux_val = mux_val | DIN;
        if (Gout)   mux_val = mux_val | G;
        if (OneOut) mux_val = mux_val | W'(1);
        // ZeroOut contributes nothing to the OR.
    end

    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        bus_next    = BusWires;
        valid_next  = 1'b0;
        confl_next  = 1'b0;
        sticky_next = ConflictSticky;
        count_next  = ConflictCount;
        last_next   = LastConflSel;

        if (sel_multi) begin
            // A conflict beats ClearErr on the same edge, locked or not.
            confl_next  = 1'b1;
            sticky_next = 1'b1;
            count_next  = (&ConflictCount) ? ConflictCount
                                           : ConflictCount + CNT_W'(1);
            last_next   = sel;
            state_next  = FAULT;
        end else if (locked) begin
            // Bus frozen; the select on the exit edge is ignored and only
            // takes effect from the next edge onwards.
            if (ClearErr) begin
                sticky_next = 1'b0;
                state_next  = IDLE;
            end
        end else begin
            if (ClearErr) begin
                sticky_next = 1'b0;
            end
            if (sel_single) begin
                bus_next   = mux_val;
                valid_next = 1'b1;
                state_next = DRIVE;
            end else begin
                bus_next   = HOLD_LAST ? BusWires : '0;
                state_next = IDLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state          <= IDLE;
            BusWires       <= '0;
            BusValid       <= 1'b0;
            Conflict       <= 1'b0;
            ConflictSticky <= 1'b0;
            ConflictCount  <= '0;
            LastConflSel   <= '0;
        end else begin
            state          <= state_next;
            BusWires       <= bus_next;
            BusValid       <= valid_next;
            Conflict       <= confl_next;
            ConflictSticky <= sticky_next;
            ConflictCount  <= count_next;
            LastConflSel   <= last_next;
        end
    end

endmodule

// File: tb/tb_bus_mux_arb.sv
// -----------------------------------------------------------------------------
// tb_bus_mux_arb
//
// Directed bench for bus_mux_arb. Three instances share every input:
//   dut_a : HOLD_LAST=1, LOCK_ON_FAULT=0
//   dut_b : HOLD_LAST=0, LOCK_ON_FAULT=0
//   dut_c : HOLD_LAST=1, LOCK_ON_FAULT=1
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_bus_mux_arb;

    logic         Clock;
    logic         Resetn;
    logic [7:0]   Rout;
    logic         DINout;
    logic         Gout;
    logic         ZeroOut;
    logic         OneOut;
    logic [127:0] R_flat;
    logic [15:0]  DIN;
    logic [15:0]  G;
    logic         ClearErr;

    logic [15:0]  a_bus,    b_bus,    c_bus;
    logic         a_valid,  b_valid,  c_valid;
    logic         a_confl,  b_confl,  c_confl;
    logic         a_sticky, b_sticky, c_sticky;
    logic [7:0]   a_count,  b_count,  c_count;
    logic [11:0]  a_last,   b_last,   c_last;

    int total;
    int bad;

    logic [15:0] reg_tab [8];
    logic [15:0] exp_tab [12];

    bus_mux_arb #(.W(16), .N_REGS(8), .HOLD_LAST(1'b1), .LOCK_ON_FAULT(1'b0), .CNT_W(8)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .Rout(Rout), .DINout(DINout), .Gout(Gout),
        .ZeroOut(ZeroOut), .OneOut(OneOut), .R_flat(R_flat), .DIN(DIN), .G(G),
        .ClearErr(ClearErr), .BusWires(a_bus), .BusValid(a_valid), .Conflict(a_confl),
        .ConflictSticky(a_sticky), .ConflictCount(a_count), .LastConflSel(a_last)
    );

    bus_mux_arb #(.W(16), .N_REGS(8), .HOLD_LAST(1'b0), .LOCK_ON_FAULT(1'b0), .CNT_W(8)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .Rout(Rout), .DINout(DINout), .Gout(Gout),
        .ZeroOut(ZeroOut), .OneOut(OneOut), .R_flat(R_flat), .DIN(DIN), .G(G),
        .ClearErr(ClearErr), .BusWires(b_bus), .BusValid(b_valid), .Conflict(b_confl),
        .ConflictSticky(b_sticky), .ConflictCount(b_count), .LastConflSel(b_last)
    );

    bus_mux_arb #(.W(16), .N_REGS(8), .HOLD_LAST(1'b1), .LOCK_ON_FAULT(1'b1), .CNT_W(8)) dut_c (
        .Clock(Clock), .Resetn(Resetn), .Rout(Rout), .DINout(DINout), .Gout(Gout),
        .ZeroOut(ZeroOut), .OneOut(OneOut), .R_flat(R_flat), .DIN(DIN), .G(G),
        .ClearErr(ClearErr), .BusWires(c_bus), .BusValid(c_valid), .Conflict(c_confl),
        .ConflictSticky(c_sticky), .ConflictCount(c_count), .LastConflSel(c_last)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Watchdog: the run is a few thousand ns; anything far beyond is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by 100000 ns");
        $fatal(1, "watchdog expired");
    end

    // {OneOut, ZeroOut, Gout, DINout, Rout}
    task automatic drive_sel(input logic [11:0] s);
        {OneOut, ZeroOut, Gout, DINout, Rout} = s;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        drive_sel(12'h000);
        ClearErr = 1'b0;
        Resetn   = 1'b0;
        #2;
        @(negedge Clock);
        Resetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        drive_sel(12'h000);
        ClearErr = 1'b0;
        Resetn   = 1'b1;
        #2;
        Resetn = 1'b0;
        #1;
        total++; if (a_bus !== 16'h0000) begin bad++; $display("FAIL reset a_bus got=%h exp=0000", a_bus); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset a_valid got=%b exp=0", a_valid); end
        total++; if (a_confl !== 1'b0) begin bad++; $display("FAIL reset a_confl got=%b exp=0", a_confl); end
        total++; if (a_sticky !== 1'b0) begin bad++; $display("FAIL reset a_sticky got=%b exp=0", a_sticky); end
        total++; if (a_count !== 8'h00) begin bad++; $display("FAIL reset a_count got=%h exp=00", a_count); end
        total++; if (a_last !== 12'h000) begin bad++; $display("FAIL reset a_last got=%h exp=000", a_last); end
        total++; if (b_bus !== 16'h0000) begin bad++; $display("FAIL reset b_bus got=%h exp=0000", b_bus); end
        total++; if (c_bus !== 16'h0000) begin bad++; $display("FAIL reset c_bus got=%h exp=0000", c_bus); end
        @(negedge Clock);
        Resetn = 1'b1;
        step();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL idle a_valid got=%b exp=0", a_valid); end
    endtask

    task automatic test_single_select();
        drive_sel(12'h004);
        step();
        total++; if (a_bus !== 16'hA5A5) begin bad++; $display("FAIL r2_sel a_bus got=%h exp=a5a5", a_bus); end
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL r2_sel a_valid got=%b exp=1", a_valid); end
        total++; if (a_confl !== 1'b0) begin bad++; $display("FAIL r2_sel a_confl got=%b exp=0", a_confl); end
    endtask

    task automatic test_sources();
        DIN = 16'hC0DE;
        G   = 16'h1234;
        for (int i = 0; i < 12; i++) begin
            drive_sel(12'(1) << i);
            step();
            total++;
            if (a_bus !== exp_tab[i] || a_valid !== 1'b1) begin
                bad++;
                $display("FAIL source_%0d a_bus/valid got=%h/%b exp=%h/1", i, a_bus, a_valid, exp_tab[i]);
            end
        end
    endtask

    task automatic test_hold();
        G = 16'h1234;
        drive_sel(12'h200);
        step();
        total++; if (a_bus !== 16'h1234) begin bad++; $display("FAIL hold_load a_bus got=%h exp=1234", a_bus); end
        total++; if (b_bus !== 16'h1234) begin bad++; $display("FAIL hold_load b_bus got=%h exp=1234", b_bus); end
        drive_sel(12'h000);
        step();
        total++; if (a_bus !== 16'h1234) begin bad++; $display("FAIL hold_last a_bus got=%h exp=1234", a_bus); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL hold_last a_valid got=%b exp=0", a_valid); end
        total++; if (b_bus !== 16'h0000) begin bad++; $display("FAIL no_hold b_bus got=%h exp=0000", b_bus); end
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL no_hold b_valid got=%b exp=0", b_valid); end
    endtask

    task automatic test_conflict();
        // a_bus is 1234 from the previous test.
        drive_sel(12'h101);
        step();
        total++; if (a_confl !== 1'b1) begin bad++; $display("FAIL conflict a_confl got=%b exp=1", a_confl); end
        total++; if (a_sticky !== 1'b1) begin bad++; $display("FAIL conflict a_sticky got=%b exp=1", a_sticky); end
        total++; if (a_count !== 8'h01) begin bad++; $display("FAIL conflict a_count got=%h exp=01", a_count); end
        total++; if (a_last !== 12'h101) begin bad++; $display("FAIL conflict a_last got=%h exp=101", a_last); end
        total++; if (a_bus !== 16'h1234) begin bad++; $display("FAIL conflict a_bus got=%h exp=1234", a_bus); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL conflict a_valid got=%b exp=0", a_valid); end
        drive_sel(12'h000);
        step();
        total++; if (a_confl !== 1'b0) begin bad++; $display("FAIL conflict_pulse a_confl got=%b exp=0", a_confl); end
        total++; if (a_sticky !== 1'b1) begin bad++; $display("FAIL conflict_keep a_sticky got=%b exp=1", a_sticky); end
        total++; if (a_count !== 8'h01) begin bad++; $display("FAIL conflict_keep a_count got=%h exp=01", a_count); end
    endtask

    task automatic test_clear_vs_conflict();
        ClearErr = 1'b1;
        drive_sel(12'h101);
        step();
        total++; if (a_sticky !== 1'b1) begin bad++; $display("FAIL clr_conf a_sticky got=%b exp=1", a_sticky); end
        total++; if (a_count !== 8'h02) begin bad++; $display("FAIL clr_conf a_count got=%h exp=02", a_count); end
        total++; if (a_confl !== 1'b1) begin bad++; $display("FAIL clr_conf a_confl got=%b exp=1", a_confl); end
        drive_sel(12'h000);
        step();
        ClearErr = 1'b0;
        total++; if (a_sticky !== 1'b0) begin bad++; $display("FAIL clear a_sticky got=%b exp=0", a_sticky); end
        total++; if (a_count !== 8'h02) begin bad++; $display("FAIL clear a_count got=%h exp=02", a_count); end
        total++; if (a_last !== 12'h101) begin bad++; $display("FAIL clear a_last got=%h exp=101", a_last); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive_sel(12'hC00);
        repeat (254) step();
        total++; if (a_count !== 8'hFE) begin bad++; $display("FAIL sat_254 a_count got=%h exp=fe", a_count); end
        step();
        total++; if (a_count !== 8'hFF) begin bad++; $display("FAIL sat_255 a_count got=%h exp=ff", a_count); end
        repeat (5) step();
        total++; if (a_count !== 8'hFF) begin bad++; $display("FAIL sat_260 a_count got=%h exp=ff", a_count); end
        total++; if (a_confl !== 1'b1) begin bad++; $display("FAIL sat_260 a_confl got=%b exp=1", a_confl); end
        total++; if (a_last !== 12'hC00) begin bad++; $display("FAIL sat_260 a_last got=%h exp=c00", a_last); end
        drive_sel(12'h000);
        step();
        total++; if (a_count !== 8'hFF) begin bad++; $display("FAIL sat_hold a_count got=%h exp=ff", a_count); end
        total++; if (a_confl !== 1'b0) begin bad++; $display("FAIL sat_hold a_confl got=%b exp=0", a_confl); end
    endtask

    task automatic test_lock();
        do_reset();
        DIN = 16'hBEEF;
        drive_sel(12'h004);
        step();
        total++; if (c_bus !== 16'hA5A5) begin bad++; $display("FAIL lock_pre c_bus got=%h exp=a5a5", c_bus); end
        drive_sel(12'h600);
        step();
        total++; if (c_confl !== 1'b1) begin bad++; $display("FAIL lock_conf c_confl got=%b exp=1", c_confl); end
        drive_sel(12'h100);
        step();
        total++; if (c_bus !== 16'hA5A5) begin bad++; $display("FAIL lock_frozen c_bus got=%h exp=a5a5", c_bus); end
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL lock_frozen c_valid got=%b exp=0", c_valid); end
        total++; if (a_bus !== 16'hBEEF) begin bad++; $display("FAIL unlock_fault a_bus got=%h exp=beef", a_bus); end
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL unlock_fault a_valid got=%b exp=1", a_valid); end
        drive_sel(12'h808);
        step();
        total++; if (c_count !== 8'h02) begin bad++; $display("FAIL lock_recount c_count got=%h exp=02", c_count); end
        total++; if (c_last !== 12'h808) begin bad++; $display("FAIL lock_recount c_last got=%h exp=808", c_last); end
        total++; if (c_bus !== 16'hA5A5) begin bad++; $display("FAIL lock_recount c_bus got=%h exp=a5a5", c_bus); end
        ClearErr = 1'b1;
        drive_sel(12'h100);
        step();
        ClearErr = 1'b0;
        total++; if (c_bus !== 16'hA5A5) begin bad++; $display("FAIL lock_exit c_bus got=%h exp=a5a5", c_bus); end
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL lock_exit c_valid got=%b exp=0", c_valid); end
        total++; if (c_sticky !== 1'b0) begin bad++; $display("FAIL lock_exit c_sticky got=%b exp=0", c_sticky); end
        step();
        total++; if (c_bus !== 16'hBEEF) begin bad++; $display("FAIL lock_after c_bus got=%h exp=beef", c_bus); end
        total++; if (c_valid !== 1'b1) begin bad++; $display("FAIL lock_after c_valid got=%b exp=1", c_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_sel(12'h101);
        step();
        drive_sel(12'h004);
        step();
        total++; if (a_bus !== 16'hA5A5 || a_valid !== 1'b1 || a_count !== 8'h01) begin
            bad++;
            $display("FAIL pre_rst a_bus/valid/count got=%h/%b/%h exp=a5a5/1/01", a_bus, a_valid, a_count);
        end
        #2;
        Resetn = 1'b0;
        #1;
        total++; if (a_bus !== 16'h0000) begin bad++; $display("FAIL async_rst a_bus got=%h exp=0000", a_bus); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL async_rst a_valid got=%b exp=0", a_valid); end
        total++; if (a_sticky !== 1'b0) begin bad++; $display("FAIL async_rst a_sticky got=%b exp=0", a_sticky); end
        total++; if (a_count !== 8'h00) begin bad++; $display("FAIL async_rst a_count got=%h exp=00", a_count); end
        total++; if (a_last !== 12'h000) begin bad++; $display("FAIL async_rst a_last got=%h exp=000", a_last); end
        total++; if (c_bus !== 16'h0000) begin bad++; $display("FAIL async_rst c_bus got=%h exp=0000", c_bus); end
        drive_sel(12'h000);
        @(negedge Clock);
        Resetn = 1'b1;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;

        reg_tab = '{16'h0101, 16'h2222, 16'hA5A5, 16'h3C3C,
                    16'h4444, 16'h5A5A, 16'h6666, 16'hFFFE};
        for (int k = 0; k < 8; k++) begin
            R_flat[k*16 +: 16] = reg_tab[k];
            exp_tab[k] = reg_tab[k];
        end
        exp_tab[8]  = 16'hC0DE;
        exp_tab[9]  = 16'h1234;
        exp_tab[10] = 16'h0000;
        exp_tab[11] = 16'h0001;

        DIN      = 16'h0000;
        G        = 16'h0000;
        ClearErr = 1'b0;
        Resetn   = 1'b1;
        drive_sel(12'h000);

        test_reset();
        test_single_select();
        test_sources();
        test_hold();
        test_conflict();
        test_clear_vs_conflict();
        test_saturation();
        test_lock();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
